// File: rtl/tlc_pkg.sv
// Shared encodings for the N-approach traffic-light controller:
// one-hot FSM states and the {g,y,r} lamp codes driven per direction.
package tlc_pkg;

    localparam logic [2:0] S_GREEN  = 3'b100;
    localparam logic [2:0] S_YELLOW = 3'b010;
    localparam logic [2:0] S_ALLRED = 3'b001;

    typedef enum logic [2:0] {
        ST_GREEN  = S_GREEN,
        ST_YELLOW = S_YELLOW,
        ST_ALLRED = S_ALLRED
    } tlc_state_e;

    localparam logic [2:0] L_G = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_R = 3'b001;

endpackage

// File: rtl/tlc_rr_pick.sv
// Rotate-priority picker: returns the first set request bit found when
// scanning phase+1, phase+2, ... (mod NDIR). 'any' is low when no bit is set,
// in which case nxt simply echoes phase.
module tlc_rr_pick #(
    parameter  int NDIR = 4,
    localparam int PW   = $clog2(NDIR)
) (
    input  logic [NDIR-1:0] req,
    input  logic [PW-1:0]   phase,
    output logic [PW-1:0]   nxt,
    output logic            any
);

    // w_cand[k] is the direction visited at scan position k (offset k+1)
    logic [PW-1:0] w_cand [NDIR];

    genvar gi;
    generate
        for (gi = 0; gi < NDIR; gi++) begin : g_cand
            logic [PW:0] w_sum;
            assign w_sum       = {1'b0, phase} + (PW+1)'(gi + 1);
            assign w_cand[gi]  = (w_sum >= (PW+1)'(NDIR)) ? PW'(w_sum - (PW+1)'(NDIR))
                                                           : PW'(w_sum);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        nxt = phase;
        any = 1'b0;
        for (int k = NDIR - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                nxt = w_cand[k];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-approach traffic-light controller: GREEN -> YELLOW -> ALLRED -> GREEN,
// intervals counted on 'tick', sticky per-direction requests served
// round-robin. Optional emergency preemption is built when the macro
// TLC_PREEMPT_EN is defined; the default build has no preempt port.
module traffic_light_ctrl_n
    import tlc_pkg::*;
#(
    parameter  int NDIR        = 4,
    parameter  int TW          = 8,
    parameter  int T_GREEN_MIN = 10,
    parameter  int T_YELLOW    = 3,
    parameter  int T_ALLRED    = 1,
    localparam int PW          = $clog2(NDIR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NDIR-1:0]   car,
`ifdef TLC_PREEMPT_EN
    input  logic              preempt,
`endif
    output logic [3*NDIR-1:0] lights,
    output logic [PW-1:0]     phase,
    output logic              busy
);

    localparam logic [TW-1:0]     C_GMIN   = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0]     C_YEL    = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0]     C_AR     = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0]     C_MAX    = '1;
    localparam logic [3*NDIR-1:0] C_RST_LT = {{(NDIR-1){L_R}}, L_G};

    tlc_state_e        r_state, w_state_next;
    logic [PW-1:0]     r_phase, w_phase_next;
    logic [TW-1:0]     r_cnt, w_cnt_next;
    logic [NDIR-1:0]   r_req, w_req_next;
    logic [3*NDIR-1:0] r_lights, w_lights_next;
    logic              r_busy;
    logic [PW-1:0]     w_nxt;
    logic              w_any;
    logic              w_preempt;
    logic              w_grant;

`ifdef TLC_PREEMPT_EN
    assign w_preempt = preempt;
`else
    assign w_preempt = 1'b0;
`endif

    tlc_rr_pick #(.NDIR(NDIR)) u_pick (
        .req   (r_req),
        .phase (r_phase),
        .nxt   (w_nxt),
        .any   (w_any)
    );

    // Next-state, next-phase and interval counter
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_grant      = 1'b0;
        case (r_state)
            ST_GREEN: begin
                if (tick && (w_preempt || (r_cnt >= C_GMIN && |r_req)))
                    w_state_next = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (tick && r_cnt == C_YEL)
                    w_state_next = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (!w_preempt && tick && r_cnt == C_AR) begin
                    w_state_next = ST_GREEN;
                    if (w_any) begin
                        w_phase_next = w_nxt;
                        w_grant      = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_GREEN;
        endcase

        if (w_state_next != r_state)
            w_cnt_next = '0;
        else if (r_state == ST_ALLRED && w_preempt)
            w_cnt_next = '0;
        else if (tick && r_cnt != C_MAX)
            w_cnt_next = r_cnt + TW'(1);
        else
            w_cnt_next = r_cnt;
    end

    // Per-direction request latch and lamp decode of the next state/phase
    genvar gi;
    generate
        for (gi = 0; gi < NDIR; gi++) begin : g_dir
            logic w_set, w_clr, w_own;
            assign w_set = car[gi] && (r_phase != PW'(gi));
            assign w_clr = w_grant && (w_nxt == PW'(gi));
            assign w_req_next[gi] = (r_req[gi] | w_set) & ~w_clr;
            assign w_own = (w_phase_next == PW'(gi));
            assign w_lights_next[3*gi +: 3] =
                (w_own && w_state_next == ST_GREEN)  ? L_G :
                (w_own && w_state_next == ST_YELLOW) ? L_Y : L_R;
        end
    endgenerate

    // FSM state, counters and registered lamp/busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_GREEN;
            r_phase  <= '0;
            r_cnt    <= '0;
            r_req    <= '0;
            r_lights <= C_RST_LT;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_phase  <= w_phase_next;
            r_cnt    <= w_cnt_next;
            r_req    <= w_req_next;
            r_lights <= w_lights_next;
            r_busy   <= (w_state_next != ST_GREEN);
        end
    end

    assign lights = r_lights;
    assign phase  = r_phase;
    assign busy   = r_busy;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed bench for traffic_light_ctrl_n with NDIR=4, T_GREEN_MIN=4,
// T_YELLOW=2, T_ALLRED=1. Inputs change 1 time unit after the rising edge
// and outputs are checked there, one line per failing comparison.
module tb_traffic_light_ctrl_n;

    localparam int NDIR = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            tick = 1'b1;
    logic [NDIR-1:0] car = '0;
    logic            preempt = 1'b0;
    logic [11:0]     lights;
    logic [1:0]      phase;
    logic            busy;

    int vec  = 0;
    int miss = 0;
    int div  = 1;
    int tcnt = 0;

    // Lamp patterns for this 4-direction build
    localparam logic [11:0] LT_ALLRED = 12'b001_001_001_001;
    localparam logic [11:0] LT_G0     = 12'b001_001_001_100;
    localparam logic [11:0] LT_Y0     = 12'b001_001_001_010;
    localparam logic [11:0] LT_G2     = 12'b001_100_001_001;
    localparam logic [11:0] LT_Y2     = 12'b001_010_001_001;

    always #5 clk = ~clk;

    traffic_light_ctrl_n #(
        .NDIR(4), .TW(8), .T_GREEN_MIN(4), .T_YELLOW(2), .T_ALLRED(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .car     (car),
`ifdef TLC_PREEMPT_EN
        .preempt (preempt),
`endif
        .lights  (lights),
        .phase   (phase),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [11:0] exp_lt,
                           input logic [1:0] exp_ph, input logic exp_busy);
        chk({tag, ".lights"}, 32'(lights), 32'(exp_lt));
        chk({tag, ".phase"},  32'(phase),  32'(exp_ph));
        chk({tag, ".busy"},   32'(busy),   32'(exp_busy));
    endtask

    // Expected lamps for a given direction holding green
    function automatic logic [11:0] green_of(input int p);
        logic [11:0] v;
        v = LT_ALLRED;
        v[3*p +: 3] = 3'b100;
        return v;
    endfunction

    function automatic logic [11:0] yellow_of(input int p);
        logic [11:0] v;
        v = LT_ALLRED;
        v[3*p +: 3] = 3'b010;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        tcnt = (tcnt + 1) % div;
        tick = (tcnt == div - 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        car = '0;
        preempt = 1'b0;
        tcnt = 0;
        tick = (div == 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int order [5] = '{1, 2, 3, 0, 1};

        // 1. Idle after reset: green on dir0 indefinitely
        do_reset();
        chk_out("t1.reset", LT_G0, 2'd0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk_out("t1.idle", LT_G0, 2'd0, 1'b0);
        end

        // 2. One-clock request on dir2: green 4, yellow 2, allred 1
        do_reset();
        car = 4'b0100;
        step();
        car = '0;
        chk_out("t2.g1", LT_G0, 2'd0, 1'b0);
        step(); chk_out("t2.g2", LT_G0, 2'd0, 1'b0);
        step(); chk_out("t2.g3", LT_G0, 2'd0, 1'b0);
        step(); chk_out("t2.y1", LT_Y0, 2'd0, 1'b1);
        step(); chk_out("t2.y2", LT_Y0, 2'd0, 1'b1);
        step(); chk_out("t2.ar", LT_ALLRED, 2'd0, 1'b1);
        step(); chk_out("t2.g_dir2", LT_G2, 2'd2, 1'b0);
        chk("t2.req", 32'(dut.r_req), 32'd0);

        // 3. Fairness with every direction waiting: order 1,2,3,0,1, 4 clk each
        do_reset();
        car = 4'b1111;
        for (int i = 0; i < 7; i++) step();
        for (int k = 0; k < 5; k++) begin
            chk_out("t3.gstart", green_of(order[k]), 2'(order[k]), 1'b0);
            for (int i = 0; i < 3; i++) step();
            chk_out("t3.glast", green_of(order[k]), 2'(order[k]), 1'b0);
            step();
            chk_out("t3.yel", yellow_of(order[k]), 2'(order[k]), 1'b1);
            for (int i = 0; i < 3; i++) step();
        end
        car = '0;

        // 4. Tick every third clock: intervals stretch to 12/6/3 clk
        div = 3;
        do_reset();
        car = 4'b0100;
        step();
        car = '0;
        for (int i = 1; i < 11; i++) step();
        chk_out("t4.g_last", LT_G0, 2'd0, 1'b0);
        step(); chk_out("t4.y_first", LT_Y0, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk_out("t4.y_last", LT_Y0, 2'd0, 1'b1);
        step(); chk_out("t4.ar_first", LT_ALLRED, 2'd0, 1'b1);
        step(); step();
        chk_out("t4.ar_last", LT_ALLRED, 2'd0, 1'b1);
        step(); chk_out("t4.g_dir2", LT_G2, 2'd2, 1'b0);
        div = 1;

        // 5. Asynchronous reset during yellow of dir2 with requests pending
        do_reset();
        car = 4'b0100;
        step();
        car = '0;
        for (int i = 0; i < 6; i++) step();
        chk_out("t5.g_dir2", LT_G2, 2'd2, 1'b0);
        car = 4'b0001;
        step();
        car = '0;
        step(); step(); step();
        chk_out("t5.y_dir2", LT_Y2, 2'd2, 1'b1);
        car = 4'b1000;
        step();
        car = '0;
        chk("t5.req_pend", 32'(dut.r_req), 32'b1001);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t5.async_rst", LT_G0, 2'd0, 1'b0);
        chk("t5.req_clr", 32'(dut.r_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef TLC_PREEMPT_EN
        // 6. Preempt at green cnt=1, hold in allred, release with no requests
        do_reset();
        step();
        chk_out("t6.g_cnt1", LT_G0, 2'd0, 1'b0);
        preempt = 1'b1;
        step(); chk_out("t6.y1", LT_Y0, 2'd0, 1'b1);
        step(); chk_out("t6.y2", LT_Y0, 2'd0, 1'b1);
        step(); chk_out("t6.ar", LT_ALLRED, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("t6.ar_hold", LT_ALLRED, 2'd0, 1'b1);
            chk("t6.cnt0", 32'(dut.r_cnt), 32'd0);
        end
        preempt = 1'b0;
        step(); chk_out("t6.g_back", LT_G0, 2'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
